// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - Instruction, condition, stop and datapath strobe bundle for control_unit.
interface control_unit_if;
   logic [31:0] IR;
   logic        CON_FF;
   logic        Stop;

   logic Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout;
   logic HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin;
   logic Inportin, Outportin, CONin, HIout, LOout, Zhighout, Zlowout;
   logic PCout, MDRout, Inportout, Cout;
   logic [4:0] opcode;
   logic       Run;

   modport master (
      input  IR, CON_FF, Stop,
      output Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
             HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
             Inportin, Outportin, CONin, HIout, LOout, Zhighout, Zlowout,
             PCout, MDRout, Inportout, Cout, opcode, Run
   );

   modport slave (
      output IR, CON_FF, Stop,
      input  Read, Write, IncPC, Gra, Grb, Grc, Rin, Rout, BAout,
             HIin, LOin, Yin, Zin, PCin, IRin, MARin, MDRin,
             Inportin, Outportin, CONin, HIout, LOout, Zhighout, Zlowout,
             PCout, MDRout, Inportout, Cout, opcode, Run
   );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - Moore FSM sequencing fetch and execute strobes; CU_STEP_EN adds Step input and WAIT state.
module control_unit (
   input  logic Clock,
   input  logic clear,
`ifdef CU_STEP_EN
   input  logic Step,
`endif
   control_unit_if.master bus
);

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_HALT = 5'b11011;

   typedef enum logic [3:0] {
      RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
`ifdef CU_STEP_EN
      , WAIT
`endif
   } state_t;

   state_t state, next, last;

   logic [4:0] op;
   logic       unused_ir;
   logic       is_alu_r, is_imm, is_md, is_un, is_mem;
   logic [4:0] imm_op;

   assign op        = bus.IR[31:27];
   assign unused_ir = ^bus.IR[26:0];

   assign is_alu_r = (op >= 5'd3)  && (op <= 5'd11);
   assign is_imm   = (op >= 5'd12) && (op <= 5'd14);
   assign is_md    = (op == 5'd15) || (op == 5'd16);
   assign is_un    = (op == 5'd17) || (op == 5'd18);
   assign is_mem   = (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
   assign imm_op   = (op == OP_ADDI) ? OP_ADD : (op == OP_ANDI) ? OP_AND : OP_OR;

   // Final T-state of each instruction; everything not listed (jr, in, out, mfhi, mflo, nop) ends in T3.
   always_comb begin
      last = T3;
      if (is_alu_r || is_imm || op == OP_LDI) last = T5;
      if (is_md || op == OP_BR)               last = T6;
      if (is_un || op == OP_JAL)              last = T4;
      if (op == OP_LD || op == OP_ST)         last = T7;
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) state <= RESET;
      else        state <= next;
   end

   always_comb begin
      next = state;
      case (state)
         RESET: next = T0;
         T0:    next = T1;
         T1:    next = T2;
         T2:    next = T3;
         HALT:  next = HALT;
`ifdef CU_STEP_EN
         WAIT: begin
            if (bus.Stop)  next = HALT;
            else if (Step) next = T0;
         end
`endif
         default: begin
            if (state == T3 && op == OP_HALT) begin
               next = HALT;
            end else if (state == last || state == T7) begin
`ifdef CU_STEP_EN
               next = bus.Stop ? HALT : WAIT;
`else
               next = bus.Stop ? HALT : T0;
`endif
            end else begin
               next = state_t'(state + 4'd1);
            end
         end
      endcase
   end

   always_comb begin
      bus.Read = 1'b0;      bus.Write = 1'b0;    bus.IncPC = 1'b0;    bus.Gra = 1'b0;
      bus.Grb = 1'b0;       bus.Grc = 1'b0;      bus.Rin = 1'b0;      bus.Rout = 1'b0;
      bus.BAout = 1'b0;     bus.HIin = 1'b0;     bus.LOin = 1'b0;     bus.Yin = 1'b0;
      bus.Zin = 1'b0;       bus.PCin = 1'b0;     bus.IRin = 1'b0;     bus.MARin = 1'b0;
      bus.MDRin = 1'b0;     bus.Inportin = 1'b0; bus.Outportin = 1'b0; bus.CONin = 1'b0;
      bus.HIout = 1'b0;     bus.LOout = 1'b0;    bus.Zhighout = 1'b0; bus.Zlowout = 1'b0;
      bus.PCout = 1'b0;     bus.MDRout = 1'b0;   bus.Inportout = 1'b0; bus.Cout = 1'b0;
      bus.opcode = 5'b00000;
      bus.Run = (state != RESET) && (state != HALT);

      case (state)
         T0: begin
            bus.PCout = 1'b1; bus.MARin = 1'b1; bus.IncPC = 1'b1; bus.Zin = 1'b1;
         end
         T1: begin
            bus.Zlowout = 1'b1; bus.PCin = 1'b1; bus.Read = 1'b1; bus.MDRin = 1'b1;
         end
         T2: begin
            bus.MDRout = 1'b1; bus.IRin = 1'b1;
         end
         T3: begin
            if (is_alu_r || is_imm) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (is_md) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Yin = 1'b1;
            end else if (is_un) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
            end else if (is_mem) begin
               bus.Grb = 1'b1; bus.BAout = 1'b1; bus.Yin = 1'b1;
            end else if (op == OP_BR) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.CONin = 1'b1;
            end else if (op == OP_JR) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
            end else if (op == OP_JAL) begin
               // Grb is expected to address R15 for the link write.
               bus.PCout = 1'b1; bus.Rin = 1'b1; bus.Grb = 1'b1;
            end else if (op == OP_IN) begin
               bus.Inportout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (op == OP_OUT) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.Outportin = 1'b1;
            end else if (op == OP_MFHI) begin
               bus.HIout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (op == OP_MFLO) begin
               bus.LOout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end
         end
         T4: begin
            if (is_alu_r) begin
               bus.Grc = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
            end else if (is_imm) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = imm_op;
            end else if (is_md) begin
               bus.Grb = 1'b1; bus.Rout = 1'b1; bus.Zin = 1'b1; bus.opcode = op;
            end else if (is_un) begin
               bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_mem) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = OP_ADD;
            end else if (op == OP_BR) begin
               bus.PCout = 1'b1; bus.Yin = 1'b1;
            end else if (op == OP_JAL) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.PCin = 1'b1;
            end
         end
         T5: begin
            if (is_alu_r || is_imm || op == OP_LDI) begin
               bus.Zlowout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (is_md) begin
               bus.Zlowout = 1'b1; bus.LOin = 1'b1;
            end else if (op == OP_LD || op == OP_ST) begin
               bus.Zlowout = 1'b1; bus.MARin = 1'b1;
            end else if (op == OP_BR) begin
               bus.Cout = 1'b1; bus.Zin = 1'b1; bus.opcode = OP_ADD;
            end
         end
         T6: begin
            if (is_md) begin
               bus.Zhighout = 1'b1; bus.HIin = 1'b1;
            end else if (op == OP_LD) begin
               bus.Read = 1'b1; bus.MDRin = 1'b1;
            end else if (op == OP_ST) begin
               bus.Gra = 1'b1; bus.Rout = 1'b1; bus.MDRin = 1'b1;
            end else if (op == OP_BR) begin
               bus.Zlowout = 1'b1; bus.PCin = bus.CON_FF;
            end
         end
         T7: begin
            if (op == OP_LD) begin
               bus.MDRout = 1'b1; bus.Gra = 1'b1; bus.Rin = 1'b1;
            end else if (op == OP_ST) begin
               bus.Write = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule
